// File: rtl/nihilist_encrypt_stream_if.sv
// nihilist_encrypt_stream_if
//   Streaming bundle for the Nihilist encryptor: key load, plaintext
//   valid/ready input side, cipher valid/ready output side and key error.
//   slave  : the encryptor (drives o_* signals)
//   master : the producer/consumer environment (drives i_* signals)
//   Ports:
//     i_w_key_load  key latch strobe            i_w_secret  packed key string
//     i_w_valid     plaintext byte valid         i_w_data    plaintext byte
//     i_w_last      final plaintext byte         o_w_ready   input accepted
//     o_r_valid     cipher byte valid            o_r_data    cipher byte
//     o_r_last      final cipher byte            i_w_ready   downstream ready
//     o_r_key_err   rejected key load pulse
interface nihilist_encrypt_stream_if #(
  parameter int p_secret_length = 6
) ();
  logic                         i_w_key_load;
  logic [p_secret_length*8-1:0] i_w_secret;
  logic                         i_w_valid;
  logic [7:0]                   i_w_data;
  logic                         i_w_last;
  logic                         o_w_ready;
  logic                         o_r_valid;
  logic [7:0]                   o_r_data;
  logic                         o_r_last;
  logic                         i_w_ready;
  logic                         o_r_key_err;

  modport slave (
    input  i_w_key_load, i_w_secret, i_w_valid, i_w_data, i_w_last, i_w_ready,
    output o_w_ready, o_r_valid, o_r_data, o_r_last, o_r_key_err
  );

  modport master (
    output i_w_key_load, i_w_secret, i_w_valid, i_w_data, i_w_last, i_w_ready,
    input  o_w_ready, o_r_valid, o_r_data, o_r_last, o_r_key_err
  );
endinterface

// File: rtl/nihilist_encrypt_stream.sv
// nihilist_encrypt_stream
//   Byte-serial Nihilist encryptor. Each accepted plaintext byte is mapped
//   through the "DANIEL"-keyed 5x5 square (non-letters keep their ASCII
//   value) and added mod 256 to the code of the current key character.
//   One output register: result appears the cycle after acceptance, with
//   full 1 byte/cycle throughput under valid/ready.
//   Ports:
//     i_w_clk    rising-edge clock
//     i_w_rst_n  asynchronous active-low reset
//     bus        nihilist_encrypt_stream_if.slave (key load, in/out streams)
//   Build option:
//     NIHILIST_UPPERCASE_FOLD_EN  fold 'a'..'z' to upper case before lookup
module nihilist_encrypt_stream #(
  parameter int p_secret_length = 6
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  nihilist_encrypt_stream_if.slave   bus
);

  localparam int KW = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;

  localparam logic [1:0] S_NOKEY = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_MSG   = 2'd2;

  function automatic logic [7:0] f_code(input logic [7:0] b);
    logic [7:0] c;
    c = b;
`ifdef NIHILIST_UPPERCASE_FOLD_EN
    if (c >= "a" && c <= "z") c = c - 8'd32;
`endif
    case (c)
      "D": f_code = 8'd11;
      "A": f_code = 8'd12;
      "N": f_code = 8'd13;
      "I": f_code = 8'd14;
      "J": f_code = 8'd14;
      "E": f_code = 8'd15;
      "L": f_code = 8'd21;
      "B": f_code = 8'd22;
      "C": f_code = 8'd23;
      "F": f_code = 8'd24;
      "G": f_code = 8'd25;
      "H": f_code = 8'd31;
      "K": f_code = 8'd32;
      "M": f_code = 8'd33;
      "O": f_code = 8'd34;
      "P": f_code = 8'd35;
      "Q": f_code = 8'd41;
      "R": f_code = 8'd42;
      "S": f_code = 8'd43;
      "T": f_code = 8'd44;
      "U": f_code = 8'd45;
      "V": f_code = 8'd51;
      "W": f_code = 8'd52;
      "X": f_code = 8'd53;
      "Y": f_code = 8'd54;
      "Z": f_code = 8'd55;
      default: f_code = c;
    endcase
  endfunction

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    key_q [p_secret_length];
  logic [7:0]    key_d [p_secret_length];
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          key_err_q, key_err_d;

  logic          load_ok;
  logic          ready;
  logic          accept;
  logic [7:0]    cipher;

  // A key load is honoured outside a message; inside one it only flags an error.
  assign load_ok = bus.i_w_key_load && (state_q != S_MSG);

  // Load in S_IDLE takes priority over a coincident input byte.
  assign ready  = (state_q != S_NOKEY) &&
                  !(bus.i_w_key_load && (state_q == S_IDLE)) &&
                  (!valid_q || bus.i_w_ready);
  assign accept = bus.i_w_valid && ready;
  assign cipher = f_code(bus.i_w_data) + key_q[k_q];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    key_d     = key_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    key_err_d = bus.i_w_key_load && (state_q == S_MSG);

    if (load_ok) begin
      state_d = S_IDLE;
      k_d     = '0;
      for (int unsigned i = 0; i < p_secret_length; i++)
        key_d[i] = f_code(bus.i_w_secret[(p_secret_length-1-i)*8 +: 8]);
    end

    if (accept) begin
      valid_d = 1'b1;
      data_d  = cipher;
      last_d  = bus.i_w_last;
      if (bus.i_w_last) begin
        state_d = S_IDLE;
        k_d     = '0;
      end else begin
        state_d = S_MSG;
        k_d     = (k_q == KW'(p_secret_length-1)) ? '0 : k_q + 1'b1;
      end
    end else if (bus.i_w_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q   <= S_NOKEY;
      k_q       <= '0;
      for (int unsigned i = 0; i < p_secret_length; i++) key_q[i] <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      key_err_q <= key_err_d;
    end
  end

  assign bus.o_w_ready   = ready;
  assign bus.o_r_valid   = valid_q;
  assign bus.o_r_data    = data_q;
  assign bus.o_r_last    = last_q;
  assign bus.o_r_key_err = key_err_q;

endmodule
